pulse_num_segmenter: RTL and testbench

PULSE_NUM_SEGMENTER -- requirements
Module: pulse_num_segmenter

---
 rtl/pulse_num_segmenter_pkg.sv | 29 ++
 rtl/segment_axis.sv | 43 ++++
 rtl/pulse_num_segmenter.sv | 162 ++++++++++++++++
 tb/tb_pulse_num_segmenter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_num_segmenter_pkg.sv
// Shared defaults and state encoding for the pulse-count segmenter.
// Imported by the top and by segment_axis.
package pulse_num_segmenter_pkg;

  localparam int DEF_IN_X_BITS  = 16;
  localparam int DEF_IN_Y_BITS  = 16;
  localparam int DEF_OUT_X_BITS = 8;
  localparam int DEF_OUT_Y_BITS = 8;
  localparam int DEF_X_FACTOR   = 4;
  localparam int DEF_Y_FACTOR   = 4;
  localparam int DEF_CHUNK_MAX  = 100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } seg_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/segment_axis.sv
// One axis of the segmenter: splits a magnitude into 2^k near-equal chunks
// and reports whether the current k keeps every chunk within CHUNK_MAX.
module segment_axis
  import pulse_num_segmenter_pkg::*;
#(
  parameter int MAG_BITS  = 19,
  parameter int OUT_BITS  = 8,
  parameter int K_BITS    = 5,
  parameter int IDX_BITS  = 19,
  parameter int CHUNK_MAX = 100
) (
  input  logic [MAG_BITS-1:0]       mag,
  input  logic                      neg,
  input  logic [K_BITS-1:0]         k,
  input  logic [IDX_BITS-1:0]       idx,
  output logic                      fits,
  output logic signed [OUT_BITS-1:0] seg
);

  localparam int CW = max_int(MAG_BITS, IDX_BITS);

  logic [MAG_BITS-1:0] mask;
  logic [MAG_BITS-1:0] base;
  logic [MAG_BITS-1:0] rem;
  logic [MAG_BITS-1:0] seg_mag;
  logic [MAG_BITS:0]   chunks;
  logic [CW-1:0]       idx_w;
  logic [CW-1:0]       rem_w;

  // A shift of k >= MAG_BITS makes the mask all ones and base zero, which is
  // still the right answer for the narrower axis.
  assign mask    = (MAG_BITS'(1) << k) - MAG_BITS'(1);
  assign base    = mag >> k;
  assign rem     = mag & mask;
  assign chunks  = {1'b0, base} + {{MAG_BITS{1'b0}}, |rem};
  assign fits    = (chunks <= (MAG_BITS+1)'(CHUNK_MAX));

  assign idx_w   = CW'(idx);
  assign rem_w   = CW'(rem);
  assign seg_mag = base + MAG_BITS'(idx_w < rem_w);
  assign seg     = neg ? -OUT_BITS'(seg_mag) : OUT_BITS'(seg_mag);

endmodule

// File: rtl/pulse_num_segmenter.sv
// Splits one upstream (x, y) pulse command into 2^k downstream segments,
// each no larger than CHUNK_MAX per axis, with exact per-axis sums.
//
// state     | meaning
// ST_IDLE   | waiting for an upstream trigger (rdy when downstream ready)
// ST_CALC   | searching the smallest k that makes every chunk fit
// ST_ISSUE  | presenting segment idx, strobing once downstream is ready
// ST_WAIT   | waiting for downstream done on the issued segment
// ST_FINISH | strobing upstream done for one cycle
module pulse_num_segmenter
  import pulse_num_segmenter_pkg::*;
#(
  parameter int IN_X_BITS  = DEF_IN_X_BITS,
  parameter int IN_Y_BITS  = DEF_IN_Y_BITS,
  parameter int OUT_X_BITS = DEF_OUT_X_BITS,
  parameter int OUT_Y_BITS = DEF_OUT_Y_BITS,
  parameter int X_FACTOR   = DEF_X_FACTOR,
  parameter int Y_FACTOR   = DEF_Y_FACTOR,
  parameter int CHUNK_MAX  = DEF_CHUNK_MAX
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [IN_X_BITS-1:0]  in_pulse_num_x,
  input  logic signed [IN_Y_BITS-1:0]  in_pulse_num_y,
  input  logic                         in_servo_pos,
  input  logic                         in_trigger,
  output logic                         in_rdy,
  output logic                         in_done,
  output logic signed [OUT_X_BITS-1:0] out_pulse_num_x,
  output logic signed [OUT_Y_BITS-1:0] out_pulse_num_y,
  output logic                         out_servo_pos,
  output logic                         out_trigger,
  input  logic                         out_rdy,
  input  logic                         out_done
);

  localparam int PWX     = IN_X_BITS + $clog2(X_FACTOR + 1);
  localparam int PWY     = IN_Y_BITS + $clog2(Y_FACTOR + 1);
  localparam int PWM     = max_int(PWX, PWY);
  localparam int KW      = $clog2(PWM + 1);
  localparam int IW      = PWM;
  localparam int OUT_MIN = min_int(OUT_X_BITS, OUT_Y_BITS);

  if (CHUNK_MAX < 1 || CHUNK_MAX > (1 << (OUT_MIN - 1)) - 1 ||
      X_FACTOR < 1 || Y_FACTOR < 1) begin : g_bad_params
    $error("pulse_num_segmenter: CHUNK_MAX or FACTOR out of range");
  end

  seg_state_t          state;
  logic [PWX-1:0]      mag_x;
  logic [PWY-1:0]      mag_y;
  logic                neg_x;
  logic                neg_y;
  logic                servo_lat;
  logic [KW-1:0]       k;
  logic [IW-1:0]       idx;

  logic signed [PWX-1:0]        px;
  logic signed [PWY-1:0]        py;
  logic [PWX-1:0]               px_mag;
  logic [PWY-1:0]               py_mag;
  logic                         fits_x;
  logic                         fits_y;
  logic signed [OUT_X_BITS-1:0] seg_x;
  logic signed [OUT_Y_BITS-1:0] seg_y;
  logic [IW:0]                  n_last;
  logic                         last_seg;

  assign px     = PWX'(in_pulse_num_x) * PWX'(X_FACTOR);
  assign py     = PWY'(in_pulse_num_y) * PWY'(Y_FACTOR);
  assign px_mag = px[PWX-1] ? -px : px;
  assign py_mag = py[PWY-1] ? -py : py;

  assign n_last   = ((IW+1)'(1) << k) - (IW+1)'(1);
  assign last_seg = ({1'b0, idx} == n_last);

  assign in_rdy = (state == ST_IDLE) && out_rdy && !reset;

  segment_axis #(
    .MAG_BITS (PWX), .OUT_BITS (OUT_X_BITS), .K_BITS (KW),
    .IDX_BITS (IW),  .CHUNK_MAX(CHUNK_MAX)
  ) u_axis_x (
    .mag (mag_x), .neg (neg_x), .k (k), .idx (idx),
    .fits(fits_x), .seg (seg_x)
  );

  segment_axis #(
    .MAG_BITS (PWY), .OUT_BITS (OUT_Y_BITS), .K_BITS (KW),
    .IDX_BITS (IW),  .CHUNK_MAX(CHUNK_MAX)
  ) u_axis_y (
    .mag (mag_y), .neg (neg_y), .k (k), .idx (idx),
    .fits(fits_y), .seg (seg_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      mag_x           <= '0;
      mag_y           <= '0;
      neg_x           <= 1'b0;
      neg_y           <= 1'b0;
      servo_lat       <= 1'b0;
      k               <= '0;
      idx             <= '0;
      out_pulse_num_x <= '0;
      out_pulse_num_y <= '0;
      out_servo_pos   <= 1'b0;
      out_trigger     <= 1'b0;
      in_done         <= 1'b0;
    end else begin
      out_trigger <= 1'b0;
      in_done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_trigger && in_rdy) begin
            mag_x     <= px_mag;
            mag_y     <= py_mag;
            neg_x     <= px[PWX-1];
            neg_y     <= py[PWY-1];
            servo_lat <= in_servo_pos;
            k         <= '0;
            idx       <= '0;
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (fits_x && fits_y) begin
            idx   <= '0;
            state <= ST_ISSUE;
          end else begin
            k <= k + KW'(1);
          end
        end
        ST_ISSUE: begin
          if (out_rdy) begin
            out_pulse_num_x <= seg_x;
            out_pulse_num_y <= seg_y;
            out_servo_pos   <= servo_lat;
            out_trigger     <= 1'b1;
            state           <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (out_done) begin
            if (last_seg) begin
              state <= ST_FINISH;
            end else begin
              idx   <= idx + IW'(1);
              state <= ST_ISSUE;
            end
          end
        end
        ST_FINISH: begin
          in_done <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_num_segmenter.sv
// Self-checking bench for pulse_num_segmenter: directed table, corner
// sequences and random commands against an arithmetic segment model.
module tb_pulse_num_segmenter;

  localparam int XF = 4;
  localparam int YF = 4;
  localparam int CM = 100;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] in_x = '0;
  logic signed [15:0] in_y = '0;
  logic               in_servo = 1'b0;
  logic               in_trigger = 1'b0;
  logic               in_rdy;
  logic               in_done;
  logic signed [7:0]  out_x;
  logic signed [7:0]  out_y;
  logic               out_servo;
  logic               out_trigger;
  logic               out_rdy = 1'b1;
  logic               out_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_num_segmenter dut (
    .clk            (clk),
    .reset          (reset),
    .in_pulse_num_x (in_x),
    .in_pulse_num_y (in_y),
    .in_servo_pos   (in_servo),
    .in_trigger     (in_trigger),
    .in_rdy         (in_rdy),
    .in_done        (in_done),
    .out_pulse_num_x(out_x),
    .out_pulse_num_y(out_y),
    .out_servo_pos  (out_servo),
    .out_trigger    (out_trigger),
    .out_rdy        (out_rdy),
    .out_done       (out_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; bit sv;
    int nseg; int fx; int fy; int lx; int ly;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint ceil_div(input longint m, input longint n);
    return (m + n - 1) / n;
  endfunction

  task automatic run_cmd(input int x, input int y, input bit sv,
                         input int rdy_low_at, input bit busy_trig,
                         input int abort_at,
                         output int nseg, output int fx, output int fy,
                         output int lx, output int ly);
    longint px, py, mx, my, n, bx, rx, by, ry, sumx, sumy;
    int k, t, dd, low_cnt, dones, cur_x, cur_y, extra;
    bit cur_s;
    int qx[$];
    int qy[$];
    px = longint'(x) * XF;
    py = longint'(y) * YF;
    mx = (px < 0) ? -px : px;
    my = (py < 0) ? -py : py;
    k = 0;
    while (ceil_div(mx, longint'(1) << k) > CM || ceil_div(my, longint'(1) << k) > CM) k++;
    n  = longint'(1) << k;
    bx = mx / n; rx = mx % n;
    by = my / n; ry = my % n;
    for (longint i = 0; i < n; i++) begin
      qx.push_back(int'((px < 0) ? -(bx + ((i < rx) ? 1 : 0)) : (bx + ((i < rx) ? 1 : 0))));
      qy.push_back(int'((py < 0) ? -(by + ((i < ry) ? 1 : 0)) : (by + ((i < ry) ? 1 : 0))));
    end
    nseg = 0; fx = 0; fy = 0; lx = 0; ly = 0;
    sumx = 0; sumy = 0; dd = -1; low_cnt = 0; dones = 0;
    cur_x = 0; cur_y = 0; cur_s = 1'b0;

    t = 0;
    while (!in_rdy && t < 100) begin @(negedge clk); t++; end
    chk("rdy_before_cmd", in_rdy, 1);
    in_x = 16'(x); in_y = 16'(y); in_servo = sv; in_trigger = 1'b1;
    @(negedge clk);

    for (int cyc = 0; cyc < 30000; cyc++) begin
      in_trigger = 1'b0;
      out_done   = 1'b0;
      if (in_done) dones++;
      if (out_trigger) begin
        if (rdy_low_at >= 0) chk("trig_rdy_low", low_cnt, 0);
        if (nseg < n) begin
          chk("seg_x", out_x, qx[nseg]);
          chk("seg_y", out_y, qy[nseg]);
          chk("seg_servo", out_servo, sv);
        end
        cur_x = out_x; cur_y = out_y; cur_s = out_servo;
        if (nseg == 0) begin fx = cur_x; fy = cur_y; end
        lx = cur_x; ly = cur_y;
        sumx += cur_x; sumy += cur_y;
        nseg++;
        if (abort_at == nseg - 1) begin
          reset = 1'b1;
          @(negedge clk);
          chk("abort_out_x", out_x, 0);
          chk("abort_out_y", out_y, 0);
          chk("abort_servo", out_servo, 0);
          chk("abort_rdy", in_rdy, 0);
          reset = 1'b0;
          extra = 0;
          for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (in_done || out_trigger) extra++;
          end
          chk("abort_no_done", extra, 0);
          chk("abort_idle_rdy", in_rdy, 1);
          return;
        end
        if (busy_trig && nseg == 1) begin
          in_x = 16'sd1234; in_trigger = 1'b1;
        end
        dd = $urandom_range(0, 3);
      end else if (low_cnt > 0) begin
        chk("rdy_low_hold_x", out_x, cur_x);
        chk("rdy_low_hold_y", out_y, cur_y);
        low_cnt--;
        if (low_cnt == 0) out_rdy = 1'b1;
      end else if (dd == 0) begin
        chk("hold_x", out_x, cur_x);
        chk("hold_y", out_y, cur_y);
        chk("hold_servo", out_servo, cur_s);
        out_done = 1'b1;
        if (rdy_low_at == nseg - 1 && nseg < n) begin
          out_rdy = 1'b0;
          low_cnt = 5;
        end
        dd = -1;
      end else if (dd > 0) begin
        dd--;
      end
      if (dones > 0) break;
      @(negedge clk);
    end
    in_trigger = 1'b0;
    out_done   = 1'b0;
    out_rdy    = 1'b1;
    if (dones == 0) begin
      chk("done_timeout", 0, 1);
      reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    end else begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        if (in_done) dones++;
      end
      chk("done_count", dones, 1);
      chk("seg_count", nseg, n);
      chk("sum_x", sumx, px);
      chk("sum_y", sumy, py);
    end
  endtask

  initial begin
    vec_t vecs[$];
    int nseg, fx, fy, lx, ly, cnt;
    int rx, ry;

    vecs.push_back('{x:10,     y:-5,    sv:0, nseg:1,    fx:40,  fy:-20,  lx:40,  ly:-20});
    vecs.push_back('{x:100,    y:30,    sv:0, nseg:4,    fx:100, fy:30,   lx:100, ly:30});
    vecs.push_back('{x:-101,   y:7,     sv:0, nseg:8,    fx:-51, fy:4,    lx:-50, ly:3});
    vecs.push_back('{x:0,      y:0,     sv:1, nseg:1,    fx:0,   fy:0,    lx:0,   ly:0});
    vecs.push_back('{x:25,     y:-25,   sv:1, nseg:1,    fx:100, fy:-100, lx:100, ly:-100});
    vecs.push_back('{x:26,     y:0,     sv:0, nseg:2,    fx:52,  fy:0,    lx:52,  ly:0});
    vecs.push_back('{x:-32768, y:32767, sv:1, nseg:2048, fx:-64, fy:64,   lx:-64, ly:63});

    repeat (3) @(negedge clk);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_servo", out_servo, 0);
    chk("rst_trigger", out_trigger, 0);
    chk("rst_in_done", in_done, 0);
    chk("rst_in_rdy", in_rdy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_rdy", in_rdy, 1);
    out_rdy = 1'b0;
    @(negedge clk);
    chk("idle_rdy_out_low", in_rdy, 0);

    // trigger while in_rdy is low must be ignored
    in_x = 16'sd5; in_trigger = 1'b1;
    @(negedge clk);
    in_trigger = 1'b0;
    out_rdy = 1'b1;
    cnt = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (out_trigger || in_done) cnt++;
    end
    chk("trig_rdy0_ignored", cnt, 0);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].x, vecs[i].y, vecs[i].sv, -1, 1'b0, -1, nseg, fx, fy, lx, ly);
      chk($sformatf("tbl%0d_nseg", i), nseg, vecs[i].nseg);
      chk($sformatf("tbl%0d_first_x", i), fx, vecs[i].fx);
      chk($sformatf("tbl%0d_first_y", i), fy, vecs[i].fy);
      chk($sformatf("tbl%0d_last_x", i), lx, vecs[i].lx);
      chk($sformatf("tbl%0d_last_y", i), ly, vecs[i].ly);
    end

    run_cmd(0, 0, 1'b1, -1, 1'b1, -1, nseg, fx, fy, lx, ly);
    chk("busy_trig_nseg", nseg, 1);
    run_cmd(-101, 7, 1'b0, 0, 1'b0, -1, nseg, fx, fy, lx, ly);
    run_cmd(100, 30, 1'b0, 2, 1'b1, -1, nseg, fx, fy, lx, ly);
    chk("busy_trig2_nseg", nseg, 4);
    run_cmd(-101, 7, 1'b1, -1, 1'b0, 1, nseg, fx, fy, lx, ly);
    chk("abort_seg_seen", nseg, 2);

    for (int r = 0; r < 25; r++) begin
      if (r % 4 == 0) begin
        rx = int'($urandom_range(0, 60)) - 30;
        ry = int'($urandom_range(0, 60)) - 30;
      end else begin
        rx = int'($urandom_range(0, 4000)) - 2000;
        ry = int'($urandom_range(0, 4000)) - 2000;
      end
      run_cmd(rx, ry, 1'($urandom_range(0, 1)), (r % 5 == 1) ? 0 : -1,
              1'b0, -1, nseg, fx, fy, lx, ly);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
